// File: rtl/isp_pkg.sv
// Shared constants and helpers for the ISP front-end blocks.
package isp_pkg;

  localparam int PIX_W         = 8;
  localparam int IMG_WIDTH_DEF = 640;

  // Line position within a frame, as seen by the 3x3 window border logic.
  typedef enum logic [1:0] {
    ROW_FIRST  = 2'd0,  // no previous line stored yet
    ROW_SECOND = 2'd1,  // only line r-1 is valid
    ROW_STEADY = 2'd2   // lines r-1 and r-2 are both valid
  } row_pos_e;

  // Address width for a buffer of the given depth (at least one bit).
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Saturating advance of the line position at the end of a line.
  function automatic row_pos_e next_row(input row_pos_e cur);
    case (cur)
      ROW_FIRST:  return ROW_SECOND;
      ROW_SECOND: return ROW_STEADY;
      default:    return ROW_STEADY;
    endcase
  endfunction

endpackage

// File: rtl/line_buffer_ram.sv
// Simple dual-port line buffer: one write port, one registered read port,
// read-first when both ports hit the same address in the same cycle.
module line_buffer_ram #(
  parameter int DW    = 8,
  parameter int DEPTH = 640,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [DW-1:0] i_wr_data,
  input  logic          i_rd_en,
  input  logic [AW-1:0] i_rd_addr,
  output logic [DW-1:0] o_rd_data
);

  // NOTE: the storage array has no reset so it maps onto block RAM; consumers
  // must never trust a word they did not write in the current frame.
  logic [DW-1:0] r_mem [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  // Registered read port; the non-blocking update above makes a same-address
  // read return the word that was there before this cycle's write.
  always_ff @(posedge clk) begin
    if (rst)          o_rd_data <= '0;
    else if (i_rd_en) o_rd_data <= r_mem[i_rd_addr];
  end

endmodule

// File: rtl/matrix_3x3_gen.sv
// 3x3 window generator for the median filter: two line buffers hold the two
// previous lines, three 3-tap shift rows form the window, and frame syncs are
// delayed to stay aligned with the window data.
module matrix_3x3_gen
  import isp_pkg::*;
#(
  parameter int DW        = PIX_W,
  parameter int IMG_WIDTH = IMG_WIDTH_DEF,
  parameter int AW        = addr_w(IMG_WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          per_frame_vsync,
  input  logic          per_frame_href,
  input  logic          per_frame_clken,
  input  logic [DW-1:0] per_img_data,
  output logic          matrix_frame_vsync,
  output logic          matrix_frame_href,
  output logic          matrix_frame_clken,
  output logic [DW-1:0] data11,
  output logic [DW-1:0] data12,
  output logic [DW-1:0] data13,
  output logic [DW-1:0] data21,
  output logic [DW-1:0] data22,
  output logic [DW-1:0] data23,
  output logic [DW-1:0] data31,
  output logic [DW-1:0] data32,
  output logic [DW-1:0] data33
);

  localparam logic [AW-1:0] COL_LAST = AW'(IMG_WIDTH - 1);

  // Input qualification and edge detection.
  logic          w_pix_en;
  logic          w_href_fall;
  logic          w_vsync_rise;
  logic [1:0]    r_href_dly;
  logic [1:0]    r_vsync_dly;
  logic          r_clken_d2;

  // Position counters.
  logic [AW-1:0] r_col_cnt;
  row_pos_e      r_row_cnt;

  // Stage 1: RAM read in flight, pixel and position registered alongside.
  logic          r_s1_valid;
  logic [DW-1:0] r_s1_pix;
  logic [AW-1:0] r_s1_col;
  row_pos_e      r_s1_row;
  logic [DW-1:0] w_lb1_rd;
  logic [DW-1:0] w_lb2_rd;

  // Stage 2: raw taps plus the position they belong to.
  logic [DW-1:0] r_p11, r_p12, r_p13;
  logic [DW-1:0] r_p21, r_p22, r_p23;
  logic [DW-1:0] r_p31, r_p32, r_p33;
  logic [AW-1:0] r_s2_col;
  row_pos_e      r_s2_row;

  logic          w_row1_on, w_row2_on, w_x1_on, w_x2_on;

  assign w_pix_en     = per_frame_clken & per_frame_href;
  assign w_href_fall  = r_href_dly[0] & ~per_frame_href;
  assign w_vsync_rise = per_frame_vsync & ~r_vsync_dly[0];

  // Two-stage sync delays; stage 0 also serves the edge detectors.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_href_dly  <= '0;
      r_vsync_dly <= '0;
      r_clken_d2  <= 1'b0;
    end else begin
      r_href_dly  <= {r_href_dly[0], per_frame_href};
      r_vsync_dly <= {r_vsync_dly[0], per_frame_vsync};
      r_clken_d2  <= r_s1_valid;
    end
  end

  // Column counter: saturates on overlong lines, restarts at end of line.
  always_ff @(posedge clk) begin
    if (rst)                                   r_col_cnt <= '0;
    else if (w_href_fall)                      r_col_cnt <= '0;
    else if (w_pix_en && r_col_cnt != COL_LAST) r_col_cnt <= r_col_cnt + AW'(1);
  end

  // Line position: new frame wins over a coincident end of line.
  always_ff @(posedge clk) begin
    if (rst)               r_row_cnt <= ROW_FIRST;
    else if (w_vsync_rise) r_row_cnt <= ROW_FIRST;
    else if (w_href_fall)  r_row_cnt <= next_row(r_row_cnt);
  end

  // lb1 takes the live pixel and returns line r-1.
  line_buffer_ram #(.DW(DW), .DEPTH(IMG_WIDTH), .AW(AW)) u_lb1 (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_pix_en),
    .i_wr_addr (r_col_cnt),
    .i_wr_data (per_img_data),
    .i_rd_en   (w_pix_en),
    .i_rd_addr (r_col_cnt),
    .o_rd_data (w_lb1_rd)
  );

  // lb2 is fed the displaced lb1 word one cycle later, once the read data is
  // available; it always lands on the previous pixel's address, so it never
  // disturbs the current lb2 read. lb2 returns line r-2.
  line_buffer_ram #(.DW(DW), .DEPTH(IMG_WIDTH), .AW(AW)) u_lb2 (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (r_s1_valid),
    .i_wr_addr (r_s1_col),
    .i_wr_data (w_lb1_rd),
    .i_rd_en   (w_pix_en),
    .i_rd_addr (r_col_cnt),
    .o_rd_data (w_lb2_rd)
  );

  // Stage 1 register: pixel and its position travel with the RAM read.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_pix   <= '0;
      r_s1_col   <= '0;
      r_s1_row   <= ROW_FIRST;
    end else begin
      r_s1_valid <= w_pix_en;
      if (w_pix_en) begin
        r_s1_pix <= per_img_data;
        r_s1_col <= r_col_cnt;
        r_s1_row <= r_row_cnt;
      end
    end
  end

  // Stage 2 tap shift: advances only on a valid pixel, holds otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      {r_p11, r_p12, r_p13} <= '0;
      {r_p21, r_p22, r_p23} <= '0;
      {r_p31, r_p32, r_p33} <= '0;
      r_s2_col              <= '0;
      r_s2_row              <= ROW_FIRST;
    end else if (r_s1_valid) begin
      {r_p11, r_p12, r_p13} <= {r_p12, r_p13, w_lb2_rd};
      {r_p21, r_p22, r_p23} <= {r_p22, r_p23, w_lb1_rd};
      {r_p31, r_p32, r_p33} <= {r_p32, r_p33, r_s1_pix};
      r_s2_col              <= r_s1_col;
      r_s2_row              <= r_s1_row;
    end
  end

  // Border masking: taps outside the image read as zero.
  assign w_row1_on = (r_s2_row == ROW_STEADY);
  assign w_row2_on = (r_s2_row != ROW_FIRST);
  assign w_x1_on   = (r_s2_col >= AW'(2));
  assign w_x2_on   = (r_s2_col != '0);

  assign data11 = (w_row1_on && w_x1_on) ? r_p11 : '0;
  assign data12 = (w_row1_on && w_x2_on) ? r_p12 : '0;
  assign data13 =  w_row1_on             ? r_p13 : '0;
  assign data21 = (w_row2_on && w_x1_on) ? r_p21 : '0;
  assign data22 = (w_row2_on && w_x2_on) ? r_p22 : '0;
  assign data23 =  w_row2_on             ? r_p23 : '0;
  assign data31 =  w_x1_on               ? r_p31 : '0;
  assign data32 =  w_x2_on               ? r_p32 : '0;
  assign data33 =  r_p33;

  assign matrix_frame_vsync = r_vsync_dly[1];
  assign matrix_frame_href  = r_href_dly[1];
  assign matrix_frame_clken = r_clken_d2;

endmodule

// File: tb/tb_matrix_3x3_gen.sv
// Directed bench for matrix_3x3_gen with an image-based reference model and
// an expected-window queue drained on each output strobe.
module tb_matrix_3x3_gen;

  localparam int W  = 8;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst, vs, hr, ce;
  logic [DW-1:0] din;
  logic          o_vs, o_hr, o_ce;
  logic [DW-1:0] d11, d12, d13, d21, d22, d23, d31, d32, d33;

  matrix_3x3_gen #(.DW(DW), .IMG_WIDTH(W), .AW(3)) dut (
    .clk                (clk),
    .rst                (rst),
    .per_frame_vsync    (vs),
    .per_frame_href     (hr),
    .per_frame_clken    (ce),
    .per_img_data       (din),
    .matrix_frame_vsync (o_vs),
    .matrix_frame_href  (o_hr),
    .matrix_frame_clken (o_ce),
    .data11 (d11), .data12 (d12), .data13 (d13),
    .data21 (d21), .data22 (d22), .data23 (d23),
    .data31 (d31), .data32 (d32), .data33 (d33)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [71:0] win;
    bit          care;
    bit          spot;
    int          row;
    int          col;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_miss = 0;
  logic [7:0]  img [0:15][0:W-1];
  int          m_row = 0, m_col = 0;
  bit          m_href_p = 0, m_vs_p = 0;
  bit          prev_pe = 0, prev_hr = 0, prev_vs = 0;
  logic [71:0] last_win = '0;
  bit          last_known = 1;
  bit          spot_en = 0;

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Reference window: pixel (r, c) of the current frame, zero outside the image.
  function automatic logic [71:0] model_win(input int r, input int c);
    logic [71:0] w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        int rr = r - 2 + i;
        int cc = c - 2 + j;
        w = {w[63:0], (rr < 0 || cc < 0) ? 8'h00 : img[rr][cc]};
      end
    return w;
  endfunction

  // One clock: drive inputs, advance the model, then check post-edge outputs.
  task automatic step(input bit r_in, input bit v, input bit h, input bit c, input logic [7:0] d);
    bit          pe;
    int          cu;
    exp_t        e;
    logic [71:0] win;
    logic [71:0] lit;
    rst = r_in; vs = v; hr = h; ce = c; din = d;
    pe = c & h & !r_in;
    if (r_in) begin
      sb.delete();
      m_row = 0; m_col = 0; m_href_p = 0; m_vs_p = 0;
    end else begin
      if (pe) begin
        cu = (m_col > W - 1) ? W - 1 : m_col;
        img[m_row][cu] = d;
        e.care = (m_col <= W - 1);
        e.win  = model_win(m_row, cu);
        e.spot = spot_en;
        e.row  = m_row;
        e.col  = cu;
        sb.push_back(e);
        m_col++;
      end
      if (m_href_p && !h) begin
        m_col = 0;
        m_row++;
      end
      if (v && !m_vs_p) m_row = 0;
      m_href_p = h;
      m_vs_p   = v;
    end
    @(posedge clk);
    #1;
    win = {d11, d12, d13, d21, d22, d23, d31, d32, d33};
    if (r_in) begin
      check("reset_flags", {69'b0, o_ce, o_hr, o_vs}, 72'b0);
      check("reset_window", win, 72'b0);
      last_win = '0; last_known = 1;
      prev_pe = 0; prev_hr = 0; prev_vs = 0;
    end else begin
      check("sync_delay", {69'b0, o_ce, o_hr, o_vs}, {69'b0, prev_pe, prev_hr, prev_vs});
      if (prev_pe) begin
        n_vec++;
        assert (sb.size() > 0) else begin
          n_miss++;
          $error("FAIL scoreboard_empty: observed 0 entries, expected at least 1");
        end
        if (sb.size() > 0) begin
          e = sb.pop_front();
          if (e.care) check($sformatf("window_r%0d_c%0d", e.row, e.col), win, e.win);
          if (e.spot && e.row == 2 && e.col == 5) begin
            lit = 72'h030405_131415_232425;
            check("ramp_r2c5", win, lit);
          end
          if (e.spot && e.row == 1 && e.col == 1) begin
            lit = 72'h000000_000001_001011;
            check("border_r1c1", win, lit);
          end
          if (e.spot && e.row == 0 && e.col == 0) begin
            lit = 72'h0;
            check("border_r0c0", win, lit);
          end
          last_win = e.win; last_known = e.care;
        end
      end else if (last_known) begin
        check("hold", win, last_win);
      end
      prev_pe = pe; prev_hr = h; prev_vs = v;
    end
  endtask

  // One line of npix pixels, one strobe every 'duty' cycles inside href.
  task automatic do_line(input int row, input int duty, input logic [7:0] base, input int npix);
    for (int c = 0; c < npix; c++) begin
      for (int g = 1; g < duty; g++) step(0, 0, 1, 0, 8'h00);
      step(0, 0, 1, 1, base + 8'(16 * row + c));
    end
  endtask

  // Blanking with a stray clken and junk data that must be ignored.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 1, 8'($urandom_range(255)));
  endtask

  initial begin
    step(1, 0, 0, 0, 8'h00);
    step(1, 0, 0, 0, 8'h00);
    step(0, 1, 0, 0, 8'h00);
    step(0, 0, 0, 0, 8'h00);

    // Frame 1: continuous ramp lines, then a gapped line, then an overrun line.
    spot_en = 1;
    for (int r = 0; r < 4; r++) begin
      do_line(r, 1, 8'h00, W);
      idle(2);
    end
    spot_en = 0;
    do_line(4, 3, 8'h00, W);
    idle(2);
    do_line(5, 1, 8'h00, W + 1);
    // vsync rises on the same cycle href falls.
    step(0, 1, 0, 0, 8'h00);
    step(0, 1, 0, 0, 8'h00);
    step(0, 0, 0, 0, 8'h00);

    // Frame 2: distinct values so stale frame-1 data would show.
    for (int r = 0; r < 3; r++) begin
      do_line(r, 1, 8'h80, W);
      idle(2);
    end
    do_line(3, 1, 8'h80, 4);
    // Reset mid-line, then the stream restarts as a fresh frame.
    for (int i = 0; i < 3; i++) step(1, 0, 1, 1, 8'hEE);
    step(0, 0, 0, 0, 8'h00);
    do_line(0, 1, 8'h40, W);
    idle(2);
    do_line(1, 1, 8'h40, W);
    idle(2);
    do_line(2, 2, 8'h40, W);
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
